// File: rtl/mips_multicycle_control_if.sv
// Datapath control bundle between the multicycle control FSM
// (master) and the MIPS datapath (slave).
interface mips_multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       ula_src_a;
  logic [1:0] ula_src_b;
  logic [1:0] pc_source;
  logic [1:0] ula_operation;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d,
    output mem_read, mem_write, ir_write,
    output mem_to_reg, reg_dst, reg_write,
    output ula_src_a, ula_src_b, pc_source,
    output ula_operation
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d,
    input  mem_read, mem_write, ir_write,
    input  mem_to_reg, reg_dst, reg_write,
    input  ula_src_a, ula_src_b, pc_source,
    input  ula_operation
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath with a
// memory-ready stall handshake and a retired-instruction counter.
module mips_multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  mips_multicycle_control_if.master bus,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   retire;

  logic is_r, is_lw, is_sw;
  logic is_beq, is_j, is_addi;

  assign is_r    = bus.opcode == 6'b000000;
  assign is_lw   = bus.opcode == 6'b100011;
  assign is_sw   = bus.opcode == 6'b101011;
  assign is_beq  = bus.opcode == 6'b000100;
  assign is_j    = bus.opcode == 6'b000010;
  assign is_addi = bus.opcode == 6'b001000;

  assign state = state_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    retired <= '0;
    else if (retire) retired <= retired + CNT_W'(1);
  end

  always_comb begin
    state_d           = state_q;
    retire            = 1'b0;
    illegal_op        = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.ula_src_a     = 1'b0;
    bus.ula_src_b     = 2'b00;
    bus.pc_source     = 2'b00;
    bus.ula_operation = 2'b00;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.ula_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        bus.ula_src_b = 2'b11;
        unique case (1'b1)
          is_lw, is_sw: state_d = S_MEM_ADDR;
          is_r:         state_d = S_EXECUTE;
          is_beq:       state_d = S_BRANCH;
          is_j:         state_d = S_JUMP;
          is_addi:      state_d = S_ADDI_EXEC;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        bus.ula_src_a = 1'b1;
        bus.ula_src_b = 2'b10;
        state_d = is_sw ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        if (bus.mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        retire         = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEM_WRITE: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECUTE: begin
        bus.ula_src_a     = 1'b1;
        bus.ula_operation = 2'b10;
        state_d           = S_R_WB;
      end
      S_R_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        bus.ula_src_a     = 1'b1;
        bus.ula_operation = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
        retire            = 1'b1;
        state_d           = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_ADDI_EXEC: begin
        bus.ula_src_a = 1'b1;
        bus.ula_src_b = 2'b10;
        state_d       = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        bus.reg_write = 1'b1;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
